// File: rtl/uart_io_pkg.sv
// Shared UART frame constants, FSM state encodings and a byte-alignment helper.
package uart_io_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic       {RD_IDLE, RD_COLLECT}                  rd_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Moves the most significant used byte of a 1-4 byte word into bits [31:24].
  function automatic logic [31:0] msb_align(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    return {d[7:0], 24'h0};
      2'd1:    return {d[15:0], 16'h0};
      2'd2:    return {d[23:0], 8'h0};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/uart_io_fifo.sv
// Byte FIFO between the UART receiver and IN requests; pops on empty and pushes on full are ignored.
module io_byte_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = count[FIFO_AW];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_io.sv
// UART responder for exec-stage OUT/IN requests: 8N1 TX serialiser, oversampled RX
// front end feeding a byte FIFO, and a read FSM that assembles 1-4 byte IN results.
module uart_io
  import uart_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_wenable,
  input  logic [1:0]  uart_wsz,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  input  logic [1:0]  uart_rsz,
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  input  logic        rxd,
  output logic        txd,
  output logic        rx_overrun,
  output logic        rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DBIT_LAST = 3'(DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [1:0]  tx_left;
  logic [31:0] tx_buf;
  logic [7:0]  tx_byte;

  assign tx_byte = tx_buf[31:24];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_left    <= '0;
      tx_buf     <= '0;
      txd        <= 1'b1;
      uart_wdone <= 1'b0;
    end else begin
      uart_wdone <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (uart_wenable) begin
            tx_buf   <= msb_align(uart_wd, uart_wsz);
            tx_left  <= uart_wsz;
            tx_cnt   <= '0;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_byte[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == DBIT_LAST) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_byte[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_left == 2'd0) begin
              uart_wdone <= 1'b1;
              tx_state   <= TX_IDLE;
            end else begin
              // Next byte follows the stop bit with no idle gap.
              tx_left  <= tx_left - 2'd1;
              tx_buf   <= {tx_buf[23:0], 8'h0};
              txd      <= 1'b0;
              tx_state <= TX_START;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX front end ----------------
  logic rxd_s1, rxd_s2, rxd_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_q  <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_q  <= rxd_s2;
    end
  end

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_push      <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      if (rx_push && fifo_full) rx_overrun <= 1'b1;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_q && !rxd_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rxd_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rxd_s2, rx_sh[7:1]};
            if (rx_bit == DBIT_LAST) rx_state <= RX_STOP;
            else                     rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          // Re-arm at the stop-bit centre so back-to-back frames are not missed.
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rxd_s2) rx_push      <= 1'b1;
            else        rx_frame_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  io_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (rx_sh),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // ---------------- READ FSM ----------------
  rd_state_t   rd_state;
  logic [1:0]  rd_left;
  logic [31:0] rd_sh;

  assign fifo_pop = (rd_state == RD_COLLECT) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state   <= RD_IDLE;
      rd_left    <= '0;
      rd_sh      <= '0;
      uart_rd    <= '0;
      uart_rdone <= 1'b0;
    end else begin
      uart_rdone <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (uart_renable) begin
            rd_left  <= uart_rsz;
            rd_sh    <= '0;
            rd_state <= RD_COLLECT;
          end
        end
        RD_COLLECT: begin
          if (!fifo_empty) begin
            if (rd_left == 2'd0) begin
              uart_rd    <= {rd_sh[23:0], fifo_dout};
              uart_rdone <= 1'b1;
              rd_state   <= RD_IDLE;
            end else begin
              rd_sh   <= {rd_sh[23:0], fifo_dout};
              rd_left <= rd_left - 2'd1;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io.sv
// Directed/randomised bench for uart_io with a frame-level TX model and a byte-queue RX/FIFO model.
module tb_uart_io;

  localparam int C = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        uart_wenable = 1'b0;
  logic [1:0]  uart_wsz = '0;
  logic [31:0] uart_wd = '0;
  logic        uart_wdone;
  logic        uart_renable = 1'b0;
  logic [1:0]  uart_rsz = '0;
  logic [31:0] uart_rd;
  logic        uart_rdone;
  logic        rxd = 1'b1;
  logic        txd;
  logic        rx_overrun;
  logic        rx_frame_err;

  uart_io #(.CLKS_PER_BIT(C), .FIFO_AW(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_wenable (uart_wenable),
    .uart_wsz     (uart_wsz),
    .uart_wd      (uart_wd),
    .uart_wdone   (uart_wdone),
    .uart_renable (uart_renable),
    .uart_rsz     (uart_rsz),
    .uart_rd      (uart_rd),
    .uart_rdone   (uart_rdone),
    .rxd          (rxd),
    .txd          (txd),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  byte unsigned rxq[$];
  logic exp_ovr = 1'b0;
  logic exp_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected txd for every cycle of the request: start, 8 data LSB first, stop; MSB used byte first.
  task automatic tx_req(input logic [1:0] sz, input logic [31:0] wd, input string tag);
    int n, bitno, byt, pos;
    logic [7:0] b;
    logic exp_bit;
    n = int'(sz) + 1;
    @(negedge clk);
    uart_wenable = 1'b1; uart_wsz = sz; uart_wd = wd;
    @(negedge clk);
    uart_wenable = 1'b0;
    for (int k = 0; k < 10 * n * C; k++) begin
      if (k > 0) @(negedge clk);
      bitno = k / C;
      byt   = bitno / 10;
      pos   = bitno % 10;
      b     = wd[8*(n-1-byt) +: 8];
      exp_bit = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : b[pos-1];
      check({tag, "_txd"}, {31'd0, txd}, {31'd0, exp_bit});
      check({tag, "_wdone_early"}, {31'd0, uart_wdone}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_wdone"}, {31'd0, uart_wdone}, 32'd1);
    check({tag, "_txd_idle"}, {31'd0, txd}, 32'd1);
    @(negedge clk);
    check({tag, "_wdone_pulse"}, {31'd0, uart_wdone}, 32'd0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (C) @(negedge clk);
    end
    rxd = stop;
    repeat (C) @(negedge clk);
    rxd = 1'b1;
    if (stop) begin
      if (rxq.size() < 16) rxq.push_back(b);
      else                 exp_ovr = 1'b1;
    end else begin
      exp_ferr = 1'b1;
      repeat (C) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] model_pop(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[23:0], rxq.pop_front()};
    return v;
  endfunction

  task automatic do_read(input logic [1:0] sz, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    uart_renable = 1'b1; uart_rsz = sz;
    @(negedge clk);
    uart_renable = 1'b0;
    for (int i = 0; i < 100 && !uart_rdone; i++) @(negedge clk);
    check({tag, "_rdone"}, {31'd0, uart_rdone}, 32'd1);
    exp = model_pop(int'(sz) + 1);
    check({tag, "_rd"}, uart_rd, exp);
  endtask

  initial begin
    logic [31:0] exp;
    logic seen;

    // Reset state
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_wdone", {31'd0, uart_wdone}, 32'd0);
    check("rst_rdone", {31'd0, uart_rdone}, 32'd0);
    check("rst_rd", uart_rd, 32'd0);
    check("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // TX: single byte, four bytes, then random requests
    tx_req(2'd0, 32'h0000_0041, "tx1");
    tx_req(2'd3, 32'h1234_5678, "tx4");
    for (int r = 0; r < 2; r++) tx_req(2'($urandom_range(0, 3)), $urandom, "txr");

    // RX two frames, then a 2-byte read with exact latency
    rx_frame(8'hAB, 1'b1);
    rx_frame(8'hCD, 1'b1);
    repeat (3) @(negedge clk);
    uart_renable = 1'b1; uart_rsz = 2'd1;
    @(negedge clk);
    uart_renable = 1'b0;
    check("rd2_t1", {31'd0, uart_rdone}, 32'd0);
    @(negedge clk);
    check("rd2_t2", {31'd0, uart_rdone}, 32'd0);
    @(negedge clk);
    check("rd2_t3", {31'd0, uart_rdone}, 32'd1);
    exp = model_pop(2);
    check("rd2_data", uart_rd, exp);
    check("rd2_const", uart_rd, 32'h0000_ABCD);
    @(negedge clk);
    check("rd2_pulse", {31'd0, uart_rdone}, 32'd0);

    // Read issued on empty FIFO, satisfied by a later frame; result held afterwards
    @(negedge clk);
    uart_renable = 1'b1; uart_rsz = 2'd0;
    @(negedge clk);
    uart_renable = 1'b0;
    repeat (5) @(negedge clk);
    check("rdw_wait", {31'd0, uart_rdone}, 32'd0);
    rx_frame(8'h7E, 1'b1);
    for (int i = 0; i < 2 * C && !uart_rdone; i++) @(negedge clk);
    check("rdw_rdone", {31'd0, uart_rdone}, 32'd1);
    exp = model_pop(1);
    check("rdw_data", uart_rd, exp);
    repeat (5) @(negedge clk);
    check("rdw_hold", uart_rd, 32'h0000_007E);
    check("rdw_pulse", {31'd0, uart_rdone}, 32'd0);

    // Overrun: 17 random frames into a 16-deep FIFO
    for (int f = 0; f < 17; f++) rx_frame(8'($urandom), 1'b1);
    check("ovr_flag", {31'd0, rx_overrun}, {31'd0, exp_ovr});
    check("ovr_ferr", {31'd0, rx_frame_err}, 32'd0);
    for (int r = 0; r < 4; r++) do_read(2'd3, "ovr_rd");
    check("ovr_sticky", {31'd0, rx_overrun}, 32'd1);

    // Framing error: byte dropped, FIFO stays empty
    rx_frame(8'h55, 1'b0);
    check("ferr_flag", {31'd0, rx_frame_err}, {31'd0, exp_ferr});
    @(negedge clk);
    uart_renable = 1'b1; uart_rsz = 2'd0;
    @(negedge clk);
    uart_renable = 1'b0;
    seen = 1'b0;
    repeat (3 * C) begin
      @(negedge clk);
      if (uart_rdone) seen = 1'b1;
    end
    check("ferr_empty", {31'd0, seen}, 32'd0);

    // Reset mid TX frame
    @(negedge clk);
    uart_wenable = 1'b1; uart_wsz = 2'd1; uart_wd = $urandom;
    @(negedge clk);
    uart_wenable = 1'b0;
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    rxq.delete();
    @(negedge clk);
    check("mrst_txd", {31'd0, txd}, 32'd1);
    check("mrst_wdone", {31'd0, uart_wdone}, 32'd0);
    check("mrst_rd", uart_rd, 32'd0);
    check("mrst_ovr", {31'd0, rx_overrun}, 32'd0);
    check("mrst_ferr", {31'd0, rx_frame_err}, 32'd0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (uart_wdone || !txd || uart_rdone) seen = 1'b1;
    end
    check("mrst_quiet", {31'd0, seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
